// File: rtl/qspi_slave_mem_if.sv
// qspi_slave_mem_if: quad-SPI bus between the team QSPI master and the slave memory
// cs_n           : chip select, active-low, driven by the master
// mosi_0..mosi_3 : nibble from master, mosi_3 is the MSB
// miso_0..miso_3 : nibble from slave, miso_3 is the MSB
interface qspi_slave_mem_if;
  logic cs_n;
  logic mosi_0, mosi_1, mosi_2, mosi_3;
  logic miso_0, miso_1, miso_2, miso_3;
  modport master (output cs_n, mosi_0, mosi_1, mosi_2, mosi_3, input miso_0, miso_1, miso_2, miso_3);
  modport slave (input cs_n, mosi_0, mosi_1, mosi_2, mosi_3, output miso_0, miso_1, miso_2, miso_3);
endinterface

// File: rtl/qspi_slave_mem.sv
// qspi_slave_mem: quad-SPI slave backed by a byte-addressable register memory
// clk        : serial clock; negedge samples MOSI, posedge drives MISO
// reset      : asynchronous, active-high
// bus        : qspi_slave_mem_if.slave (cs_n, mosi_*, miso_*)
// wel        : write-enable latch
// frame_done : one-clk pulse after a frame carrying at least one full byte ends
// last_cmd   : last command byte fully received
module qspi_slave_mem #(
  parameter int ADDR_W = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  qspi_slave_mem_if.slave bus,
  output logic wel,
  output logic frame_done,
  output logic [7:0] last_cmd
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {CMD, ADDR, WDATA, RDATA, ID, STATUS, IGNORE} state_t;
  state_t state_q, state_d;
  logic phase_q, got_q, wcmd_q, end_q, wel_q, done_q, out_en;
  logic [3:0] hi_q, lo_q, miso_q, nib;
  logic [7:0] byte_w, src, last_cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] mem_q [DEPTH];
  always_comb begin
    nib = {bus.mosi_3, bus.mosi_2, bus.mosi_1, bus.mosi_0};
    byte_w = {hi_q, nib};
    state_d = (byte_w == 8'h02 || byte_w == 8'h03) ? ADDR :
              byte_w == 8'h9F ? ID : byte_w == 8'h05 ? STATUS : IGNORE;
    src = state_q == RDATA ? mem_q[addr_q] : state_q == ID ? ID_VALUE : {6'b0, wel_q, 1'b0};
    out_en = !bus.cs_n && (state_q == RDATA || state_q == ID || state_q == STATUS);
  end
  // Byte assembly and command FSM on the sampling edge. end_q marks the
  // negedge that closed a frame with at least one full byte.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CMD;
      phase_q <= 1'b0;
      hi_q <= '0;
      addr_q <= '0;
      wel_q <= 1'b0;
      last_cmd_q <= '0;
      got_q <= 1'b0;
      wcmd_q <= 1'b0;
      end_q <= 1'b0;
      mem_q <= '{default: '0};
    end else if (bus.cs_n) begin
      end_q <= got_q;
      state_q <= CMD;
      phase_q <= 1'b0;
      got_q <= 1'b0;
      wcmd_q <= 1'b0;
      if (wcmd_q) wel_q <= 1'b0;
    end else begin
      end_q <= 1'b0;
      phase_q <= ~phase_q;
      if (!phase_q) hi_q <= nib;
      else
        case (state_q)
          CMD: begin
            last_cmd_q <= byte_w;
            got_q <= 1'b1;
            wcmd_q <= byte_w == 8'h02;
            state_q <= state_d;
            if (byte_w == 8'h06) wel_q <= 1'b1;
            else if (byte_w == 8'h04) wel_q <= 1'b0;
          end
          ADDR: begin
            addr_q <= byte_w[ADDR_W-1:0];
            state_q <= wcmd_q ? WDATA : RDATA;
          end
          WDATA: begin
            if (wel_q) mem_q[addr_q] <= byte_w;
            addr_q <= addr_q + ADDR_W'(1);
          end
          RDATA: addr_q <= addr_q + ADDR_W'(1);
          default: ;
        endcase
    end
  end
  // The slot's byte is captured on its first posedge (phase 0), so the low
  // nibble comes from the same snapshot even if memory changes meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= end_q;
      if (!out_en) miso_q <= '0;
      else if (!phase_q) {miso_q, lo_q} <= src;
      else miso_q <= lo_q;
    end
  end
  assign {bus.miso_3, bus.miso_2, bus.miso_1, bus.miso_0} = miso_q;
  assign wel = wel_q;
  assign frame_done = done_q;
  assign last_cmd = last_cmd_q;
endmodule

// File: tb/tb_qspi_slave_mem.sv
// tb_qspi_slave_mem: randomized scoreboard bench for qspi_slave_mem
module tb_qspi_slave_mem;
  logic clk, reset, wel, frame_done;
  logic [7:0] last_cmd;
  qspi_slave_mem_if bus();
  qspi_slave_mem dut (.clk(clk), .reset(reset), .bus(bus), .wel(wel), .frame_done(frame_done), .last_cmd(last_cmd));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, errors = 0, exp_frames = 0, seen_frames = 0;
  logic rd_slot = 1'b0, quiet = 1'b0, half = 1'b0;
  logic [3:0] hi_nib;
  logic [7:0] sb[$];
  logic [7:0] fb[$];
  logic [7:0] m_mem [16];
  logic m_wel;
  logic [7:0] m_last;
  logic [7:0] cmds [7] = '{8'h06, 8'h04, 8'h02, 8'h03, 8'h9F, 8'h05, 8'h00};
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [3:0] mv;
    logic [7:0] e;
    mv = {bus.miso_3, bus.miso_2, bus.miso_1, bus.miso_0};
    if (rd_slot) begin
      if (!half) begin
        hi_nib = mv;
        half = 1'b1;
      end else begin
        half = 1'b0;
        if (sb.size() == 0) chk("sb_underflow", {hi_nib, mv}, 32'hFFFF);
        else begin
          e = sb.pop_front();
          chk("miso_byte", {hi_nib, mv}, e);
        end
      end
    end else half = 1'b0;
    if (!bus.cs_n && quiet) chk("miso_quiet", mv, 0);
    if (frame_done) seen_frames++;
  end
  task automatic idle_check();
    repeat (2) @(posedge clk);
    #1;
    chk("frames", seen_frames, exp_frames);
    chk("wel", wel, m_wel);
    chk("last_cmd", last_cmd, m_last);
  endtask
  task automatic model_clear();
    foreach (m_mem[j]) m_mem[j] = 8'h00;
    m_wel = 1'b0;
    m_last = 8'h00;
  endtask
  task automatic mid_reset();
    reset = 1'b1;
    #1;
    chk("rst_miso", {bus.miso_3, bus.miso_2, bus.miso_1, bus.miso_0}, 0);
    rd_slot = 1'b0;
    quiet = 1'b0;
    sb.delete();
    bus.cs_n = 1'b1;
    model_clear();
    #2 reset = 1'b0;
  endtask
  // Drives fb as one frame of nnib_in nibbles (-1 = all), optionally resetting
  // at nibble rst_at; the reference model advances as bytes are issued.
  task automatic frame(input int nnib_in, input int rst_at);
    logic [7:0] cmd;
    logic [3:0] a;
    logic outc;
    int hdr, nnib, i;
    cmd = fb[0];
    nnib = nnib_in < 0 ? 2 * fb.size() : nnib_in;
    hdr = (cmd == 8'h02 || cmd == 8'h03) ? 2 : 1;
    outc = cmd == 8'h03 || cmd == 8'h9F || cmd == 8'h05;
    a = 4'h0;
    for (int k = 0; k < nnib; k++) begin
      i = k / 2;
      @(posedge clk);
      #1;
      if (k == rst_at) begin
        mid_reset();
        idle_check();
        return;
      end
      bus.cs_n = 1'b0;
      quiet = !outc;
      {bus.mosi_3, bus.mosi_2, bus.mosi_1, bus.mosi_0} = k[0] ? fb[i][3:0] : fb[i][7:4];
      rd_slot = outc && i >= hdr && 2 * i + 1 < nnib;
      if (!k[0] && rd_slot)
        sb.push_back(cmd == 8'h03 ? m_mem[a + 4'(i - 2)] : cmd == 8'h9F ? 8'hA5 : {6'b0, m_wel, 1'b0});
      if (k[0]) begin
        if (i == 0) begin
          m_last = cmd;
          m_wel = cmd == 8'h06 ? 1'b1 : cmd == 8'h04 ? 1'b0 : m_wel;
        end else if (i == 1 && hdr == 2) a = fb[1][3:0];
        else if (i >= 2 && cmd == 8'h02 && m_wel) m_mem[a + 4'(i - 2)] = fb[i];
      end
    end
    @(posedge clk);
    #1;
    bus.cs_n = 1'b1;
    rd_slot = 1'b0;
    quiet = 1'b0;
    {bus.mosi_3, bus.mosi_2, bus.mosi_1, bus.mosi_0} = 4'($urandom);
    if (nnib >= 2) begin
      exp_frames++;
      if (cmd == 8'h02) m_wel = 1'b0;
    end
    idle_check();
  endtask
  initial begin
    int n, nn;
    logic [7:0] c;
    reset = 1'b1;
    bus.cs_n = 1'b1;
    {bus.mosi_3, bus.mosi_2, bus.mosi_1, bus.mosi_0} = 4'h0;
    model_clear();
    #3;
    chk("rst_miso", {bus.miso_3, bus.miso_2, bus.miso_1, bus.miso_0}, 0);
    chk("rst_wel", wel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_last_cmd", last_cmd, 0);
    #9 reset = 1'b0;
    fb = {8'h9F, 8'h12, 8'h34}; frame(-1, -1);
    fb = {8'h06}; frame(-1, -1);
    fb = {8'h02, 8'h03, 8'h11, 8'h22, 8'h33}; frame(-1, -1);
    fb = {8'h03, 8'h03, 8'h00, 8'h00, 8'h00}; frame(-1, -1);
    fb = {8'h02, 8'h05, 8'h77}; frame(-1, -1);
    fb = {8'h03, 8'h05, 8'h00}; frame(-1, -1);
    fb = {8'h05, 8'hFF}; frame(-1, -1);
    fb = {8'h06}; frame(-1, -1);
    fb = {8'h05, 8'h00, 8'h00}; frame(-1, -1);
    fb = {8'h02, 8'h0F, 8'hAA, 8'hBB}; frame(-1, -1);
    fb = {8'h03, 8'h0F, 8'h00, 8'h00}; frame(-1, -1);
    fb = {8'h06}; frame(-1, -1);
    fb = {8'h02, 8'h03, 8'hCC}; frame(5, -1);
    fb = {8'h03, 8'h03, 8'h00}; frame(-1, -1);
    fb = {8'h5A, 8'h12, 8'h34}; frame(-1, -1);
    fb = {8'h06}; frame(3, -1);
    fb = {8'h03, 8'h03, 8'h00, 8'h00, 8'h00}; frame(-1, 6);
    fb = {8'h03, 8'h03, 8'h00}; frame(-1, -1);
    fb = {8'h03, 8'h0F, 8'h00}; frame(-1, -1);
    for (int r = 0; r < 80; r++) begin
      c = cmds[$urandom_range(0, 6)];
      if (c == 8'h00) c = 8'($urandom);
      fb = {c};
      n = ((c == 8'h02 || c == 8'h03) ? 1 : 0) + int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
      nn = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2 * fb.size())) : -1;
      frame(nn, -1);
    end
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
